// File: rtl/metro_mpi_pkg.sv
// Shared types and defaults for the MPI node bridge datapath.
package metro_mpi_pkg;

    localparam int FLIT_W          = 64;
    localparam int DEFAULT_CREDITS = 3;

    typedef logic [FLIT_W-1:0]                       flit_t;
    typedef logic [$clog2(DEFAULT_CREDITS+1)-1:0]    credit_t;

endpackage

// File: rtl/mpi_credit_tx_if.sv
// Local-port flit handshake plus bridge-side send/credit signals of mpi_credit_tx.
interface mpi_credit_tx_if #(
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int CREDITS    = 3
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam int FW = $clog2(FIFO_DEPTH + 1);

    logic              in_valid_i;
    logic [DATA_W-1:0] in_data_i;
    logic              in_ready_o;
    logic              xfer_en_i;
    logic              yummy_i;
    logic              valid_o;
    logic [DATA_W-1:0] data_o;
    logic [CW-1:0]     credit_o;
    logic [FW-1:0]     fifo_count_o;
    logic              overflow_err_o;

    modport slave (
        input  in_valid_i, in_data_i, xfer_en_i, yummy_i,
        output in_ready_o, valid_o, data_o, credit_o, fifo_count_o, overflow_err_o
    );

    modport master (
        output in_valid_i, in_data_i, xfer_en_i, yummy_i,
        input  in_ready_o, valid_o, data_o, credit_o, fifo_count_o, overflow_err_o
    );

endinterface

// File: rtl/mpi_flit_fifo.sv
// Synchronous flit FIFO with registered occupancy; head word is read combinationally.
module mpi_flit_fifo #(
    parameter  int DATA_W = 64,
    parameter  int DEPTH  = 8,
    localparam int AW     = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign full_o  = (r_count == CNT_W'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign rdata_o = r_mem[r_rd_ptr];

    // Guard against writes when full and reads when empty so the count stays consistent.
    assign w_push = push_i & ~full_o;
    assign w_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mpi_credit_tx.sv
// Credit-gated transmit stage: buffers local flits and releases one per exchange slot while remote credit remains.
module mpi_credit_tx
    import metro_mpi_pkg::*;
#(
    parameter  int DATA_W     = FLIT_W,
    parameter  int FIFO_DEPTH = 8,
    parameter  int CREDITS    = DEFAULT_CREDITS,
    localparam int CW         = $clog2(CREDITS + 1),
    localparam int FW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    mpi_credit_tx_if.slave bus
);

    localparam logic [CW-1:0] CMAX = CW'(CREDITS);

    logic [CW-1:0]     r_credit;
    logic              r_ovf;
    logic              r_vld_p1;
    logic [DATA_W-1:0] r_data_p1;

    logic [DATA_W-1:0] w_head;
    logic [FW-1:0]     w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_send;
    logic              w_cred_ovf;

    // Saturating credit update; a send always has credit, so only the top end needs clamping.
    function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] cur,
                                                  input logic          send,
                                                  input logic          yummy);
        logic [CW-1:0] nxt;
        nxt = cur;
        if (send && !yummy)                  nxt = cur - CW'(1);
        else if (!send && yummy && cur != CMAX) nxt = cur + CW'(1);
        return nxt;
    endfunction

    assign w_push     = bus.in_valid_i & ~w_full;
    assign w_send     = bus.xfer_en_i & ~w_empty & (r_credit != '0);
    assign w_cred_ovf = bus.yummy_i & ~w_send & (r_credit == CMAX);

    mpi_flit_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .pop_i   (w_send),
        .wdata_i (bus.in_data_i),
        .rdata_o (w_head),
        .count_o (w_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // p0 -> p1: popped head is registered and presented to the bridge for one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_credit  <= CMAX;
            r_ovf     <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
        end else begin
            r_credit <= credit_next(r_credit, w_send, bus.yummy_i);
            r_ovf    <= r_ovf | w_cred_ovf;
            r_vld_p1 <= w_send;
            if (w_send) r_data_p1 <= w_head;
        end
    end

    assign bus.in_ready_o     = ~w_full;
    assign bus.valid_o        = r_vld_p1;
    assign bus.data_o         = r_data_p1;
    assign bus.credit_o       = r_credit;
    assign bus.fifo_count_o   = w_count;
    assign bus.overflow_err_o = r_ovf;

endmodule

// File: tb/tb_mpi_credit_tx.sv
// Directed bench for mpi_credit_tx: reset, credit gating, full FIFO, send+yummy, credit overflow.
module tb_mpi_credit_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errs   = 0;

    always #5 clk = ~clk;

    mpi_credit_tx_if #(.DATA_W(64), .FIFO_DEPTH(8), .CREDITS(3)) bus ();

    mpi_credit_tx #(.DATA_W(64), .FIFO_DEPTH(8), .CREDITS(3)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [63:0] d,
                           input int cred, input int cnt);
        chk({tag, ".valid"},  64'(bus.valid_o),      64'(v));
        chk({tag, ".data"},   bus.data_o,            d);
        chk({tag, ".credit"}, 64'(bus.credit_o),     64'(cred));
        chk({tag, ".count"},  64'(bus.fifo_count_o), 64'(cnt));
    endtask

    initial begin
        bus.in_valid_i = 1'b0;
        bus.in_data_i  = '0;
        bus.xfer_en_i  = 1'b0;
        bus.yummy_i    = 1'b0;

        // Reset held for two edges
        rst = 1'b1;
        tick();
        tick();
        chk_out("rst", 1'b0, 64'h0, 3, 0);
        chk("rst.ready", 64'(bus.in_ready_o), 64'd1);
        chk("rst.ovf", 64'(bus.overflow_err_o), 64'd0);
        rst = 1'b0;

        // Push A0..A3 with sending enabled; only three credits available
        bus.xfer_en_i  = 1'b1;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 64'hA0; tick(); chk_out("p0", 1'b0, 64'h0,  3, 1);
        bus.in_data_i  = 64'hA1; tick(); chk_out("p1", 1'b1, 64'hA0, 2, 1);
        bus.in_data_i  = 64'hA2; tick(); chk_out("p2", 1'b1, 64'hA1, 1, 1);
        bus.in_data_i  = 64'hA3; tick(); chk_out("p3", 1'b1, 64'hA2, 0, 1);
        bus.in_valid_i = 1'b0;
        tick(); chk_out("hold0", 1'b0, 64'hA2, 0, 1);
        tick(); chk_out("hold1", 1'b0, 64'hA2, 0, 1);

        // One credit returned releases A3
        bus.yummy_i = 1'b1; tick(); chk_out("ym0", 1'b0, 64'hA2, 1, 1);
        bus.yummy_i = 1'b0; tick(); chk_out("ym1", 1'b1, 64'hA3, 0, 0);
        tick(); chk_out("ym2", 1'b0, 64'hA3, 0, 0);

        // Refill credit to 3 with sending disabled
        bus.xfer_en_i = 1'b0;
        bus.yummy_i   = 1'b1;
        tick(); tick(); tick();
        bus.yummy_i   = 1'b0;
        chk("refill.credit", 64'(bus.credit_o), 64'd3);
        chk("refill.ovf", 64'(bus.overflow_err_o), 64'd0);

        // Fill FIFO with 0x10..0x17, then offer 0x18 which must be refused
        bus.in_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_data_i = 64'h10 + 64'(i);
            tick();
        end
        chk("full.count", 64'(bus.fifo_count_o), 64'd8);
        chk("full.ready", 64'(bus.in_ready_o), 64'd0);
        bus.in_data_i = 64'h18;
        tick();
        chk("full9.count", 64'(bus.fifo_count_o), 64'd8);
        chk("full9.valid", 64'(bus.valid_o), 64'd0);
        bus.in_valid_i = 1'b0;

        // Drain in order; second send coincides with a yummy, keeping credit at 2
        bus.xfer_en_i = 1'b1;
        tick(); chk_out("d0", 1'b1, 64'h10, 2, 7);
        chk("d0.ready", 64'(bus.in_ready_o), 64'd1);
        bus.yummy_i = 1'b1; tick(); chk_out("d1", 1'b1, 64'h11, 2, 6);
        bus.yummy_i = 1'b0; tick(); chk_out("d2", 1'b1, 64'h12, 1, 5);
        tick(); chk_out("d3", 1'b1, 64'h13, 0, 4);
        tick(); chk_out("d4", 1'b0, 64'h13, 0, 4);

        // Restore credit, then drain the rest with a yummy per send
        bus.xfer_en_i = 1'b0;
        bus.yummy_i   = 1'b1;
        tick(); tick(); tick();
        chk("r2.credit", 64'(bus.credit_o), 64'd3);
        bus.xfer_en_i = 1'b1;
        tick(); chk_out("e0", 1'b1, 64'h14, 3, 3);
        tick(); chk_out("e1", 1'b1, 64'h15, 3, 2);
        tick(); chk_out("e2", 1'b1, 64'h16, 3, 1);
        tick(); chk_out("e3", 1'b1, 64'h17, 3, 0);
        bus.yummy_i = 1'b0;
        tick(); chk_out("e4", 1'b0, 64'h17, 3, 0);
        chk("e4.ovf", 64'(bus.overflow_err_o), 64'd0);

        // Yummy while idle at max credit sets the sticky error
        bus.xfer_en_i = 1'b0;
        bus.yummy_i   = 1'b1; tick();
        chk("ovf.credit", 64'(bus.credit_o), 64'd3);
        chk("ovf.set", 64'(bus.overflow_err_o), 64'd1);
        bus.yummy_i   = 1'b0; tick(); tick();
        chk("ovf.sticky", 64'(bus.overflow_err_o), 64'd1);

        // Reset mid-operation with a flit in flight and one buffered
        bus.xfer_en_i  = 1'b1;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 64'h55; tick();
        bus.in_data_i  = 64'h66; tick();
        bus.in_valid_i = 1'b0;
        bus.xfer_en_i  = 1'b0;
        chk_out("pre", 1'b1, 64'h55, 2, 1);
        rst = 1'b1; tick();
        chk_out("mrst", 1'b0, 64'h0, 3, 0);
        chk("mrst.ovf", 64'(bus.overflow_err_o), 64'd0);
        chk("mrst.ready", 64'(bus.in_ready_o), 64'd1);
        rst = 1'b0;
        tick();
        chk_out("post", 1'b0, 64'h0, 3, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
